uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Parses framed UART command bytes into multi-word burst writes and reads on NUM_CH memory channels: data, weight, heap, op and inference memories.
- Sits between the uart_rx byte stream and the memory ports at top level.
- Successor to the fixed single-word, fixed-target loader:
  - parametrised channel count, word width and read latency;
  - adds burst length, auto-increment addressing, read-back over tx, and an inter-byte timeout.

Parameters:
- NUM_CH, 4, number of target memory channels; legal channel ids are 0..NUM_CH-1.
- WIDTH, 64, memory word width in bits; must be a multiple of 8. BYTES = WIDTH/8.
- ADDR_W, 11, memory address width; the header carries 16 bits and the upper bits are dropped.
- RD_LATENCY, 2, cycles from mem_re to valid mem_rdata; minimum 1.
- TIMEOUT_CYCLES, 100000, maximum idle cycles between rx bytes inside a frame.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- mem_addr  out  ADDR_W  shared address.
- mem_wdata  out  WIDTH  write word.
- mem_we  out  NUM_CH  one-hot write enable, one-cycle pulse.
- mem_re  out  NUM_CH  one-hot read enable, one-cycle pulse.
- mem_rdata  in  NUM_CH*WIDTH  read words; channel c occupies bits [c*WIDTH +: WIDTH].
- busy  out  1  high whenever state != HDR_CMD.
- frame_done  out  1  one-cycle pulse when a frame completes normally.
- frame_err  out  1  one-cycle pulse on any error.

Behaviour:
- Reset (rst_in low, asynchronous):
  - state = HDR_CMD;
  - all outputs 0, including tx_data, mem_addr and mem_wdata;
  - counters and shift register cleared.
- Reset mid-frame discards the frame with no further we/re and no tx.
- Frame format is 4 header bytes, then payload:
  - B0 = {rd, 2'b00, ch[4:0]};
  - B1 = addr[7:0];
  - B2 = addr[15:8];
  - B3 = N-1, where N is the burst length in words (1..256).
- States:
  - HDR_CMD → HDR_AL → HDR_AH → HDR_LEN. Each transition consumes one rx_valid byte.
  - From HDR_LEN:
    - rd=0 and ch<NUM_CH → WR_FILL;
    - rd=1 and ch<NUM_CH → RD_REQ;
    - ch≥NUM_CH and rd=0 → DISCARD, with frame_err pulsed on the HDR_LEN byte;
    - ch≥NUM_CH and rd=1 → HDR_CMD, with frame_err pulsed on the HDR_LEN byte.
  - WR_FILL:
    - each byte fills the word LSB-byte-first (first byte → bits [7:0]);
    - on the BYTES-th byte, next cycle: mem_we[ch]=1, mem_wdata = word, mem_addr = current address;
    - address += 1, wrapping modulo 2^ADDR_W;
    - if words remain → WR_FILL, else frame_done pulse → HDR_CMD.
  - DISCARD: consume N*BYTES bytes without any write, then → HDR_CMD.
  - RD_REQ: mem_re[ch]=1 for one cycle at the current address → RD_WAIT.
  - RD_WAIT:
    - count RD_LATENCY cycles;
    - capture that channel's slice of mem_rdata in the cycle it becomes valid, i.e. exactly RD_LATENCY cycles after mem_re;
    - → RD_SEND.
  - RD_SEND:
    - present bytes LSB first; tx_valid high with tx_data stable until tx_ready;
    - advance one byte per accepted handshake;
    - back-to-back bytes are allowed with tx_valid held high;
    - after BYTES bytes: address += 1; if words remain → RD_REQ, else frame_done → HDR_CMD.
- Latency: the write pulse comes 1 cycle after the final payload byte's rx_valid.
- rx_valid during RD_REQ, RD_WAIT or RD_SEND:
  - the byte is ignored and frame_err pulses;
  - the read continues.
- Timeout applies in HDR_AL, HDR_AH, HDR_LEN, WR_FILL and DISCARD:
  - a counter resets on each rx_valid;
  - on reaching TIMEOUT_CYCLES: frame_err pulses and state → HDR_CMD;
  - a partial word is never written.
- The timeout does not apply in HDR_CMD or in the read states; a stalled tx waits indefinitely.
- frame_done and frame_err are never high in the same cycle.
- At most one bit of mem_we or mem_re is set; they are never set together.

Test Plan:
- Write ch0, addr 0x0005, N=2 (B3=0x01), 16 payload bytes 0x00..0x0F:
  - mem_we=4'b0001 at addr 5 with wdata 0x0706050403020100;
  - then at addr 6 with wdata 0x0F0E0D0C0B0A0908;
  - frame_done pulses once.
- Read ch2, addr 0x07FF, N=2, with mem_rdata ch2 = 0x1122334455667788 at 0x7FF and 0xAABBCCDDEEFF0011 at 0x000:
  - tx bytes 88,77,66,55,44,33,22,11 then 11,00,FF,EE,DD,CC,BB,AA;
  - the second mem_re is at addr 0 (wrap);
  - tx_ready toggled randomly → no byte lost or duplicated.
- Header B0=0x05 (ch5 ≥ NUM_CH), N=1, 8 payload bytes:
  - frame_err pulses once, no mem_we;
  - the next frame is decoded normally.
- Write frame stalls after 3 of 8 payload bytes for TIMEOUT_CYCLES:
  - frame_err pulses, no mem_we, busy=0;
  - the subsequent valid frame writes correctly.
- rst_in asserted low mid-payload and during RD_SEND:
  - outputs zero immediately, asynchronously;
  - after release, HDR_CMD accepts a new frame.
- rx_valid injected during RD_WAIT:
  - frame_err pulses;
  - read data on tx is still correct and complete.

Source files
------------

// File: rtl/uart_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_loader
// Description : Turns framed UART command bytes into multi-word burst writes
//               and read-backs on NUM_CH memory channels.
//               Frame = {rd,2'b00,ch[4:0]}, addr[7:0], addr[15:8], N-1,
//               followed by N*BYTES payload bytes for writes.
//               Reads return N words over tx, least-significant byte first.
// Ports       : clk_in/rst_in         clock, asynchronous active-low reset
//               rx_data/rx_valid      incoming byte stream
//               tx_data/tx_valid/     outgoing read-back bytes
//               tx_ready              (valid is held until ready)
//               mem_addr/mem_wdata/   shared memory port, one-hot
//               mem_we/mem_re/        write/read enables, channel c read
//               mem_rdata             data in mem_rdata[c*WIDTH +: WIDTH]
//               busy/frame_done/      status: not idle, normal completion,
//               frame_err             error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_loader #(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 64,
    parameter int ADDR_W         = 11,
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    output logic [NUM_CH-1:0]       mem_we,
    output logic [NUM_CH-1:0]       mem_re,
    input  logic [NUM_CH*WIDTH-1:0] mem_rdata,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    frame_err
);

    localparam int c_BYTES  = WIDTH / 8;
    localparam int c_BCNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_LAT_W  = $clog2(RD_LATENCY + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] c_HDR_CMD = 4'd0;
    localparam logic [3:0] c_HDR_AL  = 4'd1;
    localparam logic [3:0] c_HDR_AH  = 4'd2;
    localparam logic [3:0] c_HDR_LEN = 4'd3;
    localparam logic [3:0] c_WR_FILL = 4'd4;
    localparam logic [3:0] c_DISCARD = 4'd5;
    localparam logic [3:0] c_RD_REQ  = 4'd6;
    localparam logic [3:0] c_RD_WAIT = 4'd7;
    localparam logic [3:0] c_RD_SEND = 4'd8;

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic                r_rd;
    logic [4:0]          r_ch;
    logic [7:0]          r_addr_lo;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;        // words remaining minus one
    logic [WIDTH-1:0]    r_word;
    logic [c_BCNT_W-1:0] r_byte_cnt;
    logic [c_LAT_W-1:0]  r_lat;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [NUM_CH-1:0]   r_mem_we;
    logic [WIDTH-1:0]    r_mem_wdata;
    logic                r_frame_done;
    logic                r_frame_err;
    logic                r_err_pend;

    logic                w_err_set;
    logic                w_done_set;
    logic                w_timed;
    logic                w_tmo_hit;
    logic                w_byte_last;
    logic                w_lat_hit;
    logic                w_ch_ok;
    logic [NUM_CH-1:0]   w_ch_onehot;
    logic [WIDTH-1:0]    w_rd_slice;
    logic [WIDTH-1:0]    w_fill_word;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    assign w_timed     = (r_state == c_HDR_AL)  || (r_state == c_HDR_AH) ||
                         (r_state == c_HDR_LEN) || (r_state == c_WR_FILL) ||
                         (r_state == c_DISCARD);
    assign w_tmo_hit   = (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1)) && !rx_valid;
    assign w_byte_last = (r_byte_cnt == c_BCNT_W'(c_BYTES - 1));
    assign w_lat_hit   = (r_lat == c_LAT_W'(RD_LATENCY));
    assign w_ch_ok     = ({27'd0, r_ch} < 32'(NUM_CH));
    // Payload arrives LSB first, so each new byte enters at the top and the
    // word shifts down; after BYTES bytes the first one sits in [7:0].
    assign w_fill_word = WIDTH'({rx_data, r_word} >> 8);

    always_comb begin
        w_ch_onehot = '0;
        w_rd_slice  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == 5'(c)) begin
                w_ch_onehot[c] = 1'b1;
                w_rd_slice     = mem_rdata[c*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_HDR_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and frame events
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            c_HDR_CMD: begin
                if (rx_valid) w_state_nxt = c_HDR_AL;
            end
            c_HDR_AL, c_HDR_AH: begin
                if (rx_valid) begin
                    w_state_nxt = (r_state == c_HDR_AL) ? c_HDR_AH : c_HDR_LEN;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = c_HDR_CMD;
                end
            end
            c_HDR_LEN: begin
                if (rx_valid) begin
                    if (w_ch_ok) begin
                        w_state_nxt = r_rd ? c_RD_REQ : c_WR_FILL;
                    end else begin
                        // Bad channel on a write still has to swallow its payload.
                        w_err_set   = 1'b1;
                        w_state_nxt = r_rd ? c_HDR_CMD : c_DISCARD;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = c_HDR_CMD;
                end
            end
            c_WR_FILL, c_DISCARD: begin
                if (rx_valid) begin
                    if (w_byte_last && (r_len == 8'd0)) begin
                        w_done_set  = (r_state == c_WR_FILL);
                        w_state_nxt = c_HDR_CMD;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = c_HDR_CMD;
                end
            end
            c_RD_REQ: begin
                w_err_set   = rx_valid;
                w_state_nxt = c_RD_WAIT;
            end
            c_RD_WAIT: begin
                w_err_set = rx_valid;
                if (w_lat_hit) w_state_nxt = c_RD_SEND;
            end
            c_RD_SEND: begin
                w_err_set = rx_valid;
                if (tx_ready && w_byte_last) begin
                    if (r_len == 8'd0) begin
                        w_done_set  = 1'b1;
                        w_state_nxt = c_HDR_CMD;
                    end else begin
                        w_state_nxt = c_RD_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = c_HDR_CMD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        mem_re   = '0;
        tx_valid = 1'b0;
        tx_data  = '0;
        if (r_state == c_RD_REQ) begin
            mem_re = w_ch_onehot;
        end
        if (r_state == c_RD_SEND) begin
            tx_valid = 1'b1;
            tx_data  = r_word[7:0];
        end
    end

    assign busy       = (r_state != c_HDR_CMD);
    assign mem_addr   = r_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd         <= 1'b0;
            r_ch         <= '0;
            r_addr_lo    <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_word       <= '0;
            r_byte_cnt   <= '0;
            r_lat        <= '0;
            r_tmo        <= '0;
            r_mem_we     <= '0;
            r_mem_wdata  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_pend   <= 1'b0;
        end else begin
            r_mem_we     <= '0;
            r_frame_done <= w_done_set;
            // A stray rx byte on the final read handshake would collide with
            // the done pulse; the error is held back one cycle instead.
            r_frame_err  <= (w_err_set || r_err_pend) && !w_done_set;
            r_err_pend   <= (w_err_set || r_err_pend) && w_done_set;

            if (rx_valid || !w_timed) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end

            // Write address advances after the pulse so mem_addr is correct
            // during the pulse cycle itself.
            if (r_mem_we != '0) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            case (r_state)
                c_HDR_CMD: begin
                    if (rx_valid) begin
                        r_rd <= rx_data[7];
                        r_ch <= rx_data[4:0];
                    end
                end
                c_HDR_AL: begin
                    if (rx_valid) r_addr_lo <= rx_data;
                end
                c_HDR_AH: begin
                    if (rx_valid) r_addr <= ADDR_W'({rx_data, r_addr_lo});
                end
                c_HDR_LEN: begin
                    if (rx_valid) begin
                        r_len      <= rx_data;
                        r_byte_cnt <= '0;
                    end
                end
                c_WR_FILL, c_DISCARD: begin
                    if (rx_valid) begin
                        r_word <= w_fill_word;
                        if (w_byte_last) begin
                            r_byte_cnt <= '0;
                            r_len      <= r_len - 8'd1;
                            if (r_state == c_WR_FILL) begin
                                r_mem_we    <= w_ch_onehot;
                                r_mem_wdata <= w_fill_word;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
                        end
                    end
                end
                c_RD_REQ: begin
                    r_lat <= c_LAT_W'(1);
                end
                c_RD_WAIT: begin
                    if (w_lat_hit) begin
                        r_word     <= w_rd_slice;
                        r_byte_cnt <= '0;
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end
                c_RD_SEND: begin
                    if (tx_ready) begin
                        r_word <= r_word >> 8;
                        if (w_byte_last) begin
                            r_byte_cnt <= '0;
                            r_len      <= r_len - 8'd1;
                            r_addr     <= r_addr + ADDR_W'(1);
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_loader
// Description : Directed self-checking bench for uart_frame_loader with a
//               latency-accurate memory model and write/read/tx scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_loader;

    localparam int NUM_CH         = 4;
    localparam int WIDTH          = 64;
    localparam int ADDR_W         = 11;
    localparam int RD_LATENCY     = 2;
    localparam int TIMEOUT_CYCLES = 500;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [ADDR_W-1:0]       mem_addr;
    logic [WIDTH-1:0]        mem_wdata;
    logic [NUM_CH-1:0]       mem_we;
    logic [NUM_CH-1:0]       mem_re;
    logic [NUM_CH*WIDTH-1:0] mem_rdata;
    logic                    busy;
    logic                    frame_done;
    logic                    frame_err;

    uart_frame_loader #(
        .NUM_CH        (NUM_CH),
        .WIDTH         (WIDTH),
        .ADDR_W        (ADDR_W),
        .RD_LATENCY    (RD_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int bad_cnt   = 0;
    int unexp_cnt = 0;

    logic [78:0] exp_wr[$];   // {we, addr, wdata}
    logic [14:0] exp_re[$];   // {re, addr}
    logic [7:0]  exp_tx[$];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] onehot(input int ch);
        onehot = 4'b0001 << ch;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        oh2idx = 2'd0;
        for (int i = 0; i < NUM_CH; i++) if (oh[i]) oh2idx = 2'(i);
    endfunction

    // ------------------------------------------------------------------
    // Memory model: data appears exactly RD_LATENCY (=2) cycles after
    // mem_re and only on the requested channel; anything else reads junk.
    // ------------------------------------------------------------------
    logic [63:0] mem_model [NUM_CH][2048];
    logic        preloaded = 1'b0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [1:0]  c1, c2;
    logic [63:0] d1, d2;

    always @(posedge clk_in) begin
        if (!preloaded) begin
            mem_model[2][11'h7FF] <= 64'h1122334455667788;
            mem_model[2][11'h000] <= 64'hAABBCCDDEEFF0011;
            preloaded <= 1'b1;
        end
        v1 <= |mem_re;
        c1 <= oh2idx(mem_re);
        d1 <= mem_model[oh2idx(mem_re)][mem_addr];
        v2 <= v1;
        c2 <= c1;
        d2 <= d1;
        if (|mem_we) mem_model[oh2idx(mem_we)][mem_addr] <= mem_wdata;
    end

    always_comb begin
        mem_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mem_rdata[c*64 +: 64] = (v2 && (c2 == 2'(c))) ? d2 : {16'hBAD0, 48'(c)};
        end
    end

    // ------------------------------------------------------------------
    // Monitor: sampled on the falling edge, pops scoreboards.
    // ------------------------------------------------------------------
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            prev_hold = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
            if (frame_done && frame_err) bad_cnt++;
            if (($countones(mem_we) > 1) || ($countones(mem_re) > 1) || (|mem_we && |mem_re))
                bad_cnt++;
            if (|mem_we) begin
                if (exp_wr.size() == 0) unexp_cnt++;
                else check("write", {mem_we, mem_addr, mem_wdata}, exp_wr.pop_front());
            end
            if (|mem_re) begin
                if (exp_re.size() == 0) unexp_cnt++;
                else check("read_req", {mem_re, mem_addr}, exp_re.pop_front());
            end
            if (prev_hold && tx_valid) check("tx_hold", tx_data, prev_data);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) unexp_cnt++;
                else check("tx_byte", tx_data, exp_tx.pop_front());
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    // Random transmitter back-pressure.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic rd, input logic [4:0] ch, input logic [15:0] addr, input int n);
        logic [15:0] a;
        a = addr;
        send_byte({rd, 2'b00, ch});
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        send_byte(8'(n - 1));
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int b = 0; b < 8; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic push_write(input int ch, input int addr, input logic [63:0] w);
        exp_wr.push_back({onehot(ch), 11'(addr), w});
    endtask

    task automatic push_read(input int ch, input int addr, input int n);
        logic [63:0] w;
        logic [10:0] a;
        for (int i = 0; i < n; i++) begin
            a = 11'(addr + i);
            exp_re.push_back({onehot(ch), a});
            w = mem_model[ch][a];
            for (int b = 0; b < 8; b++) exp_tx.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || exp_wr.size() != 0 || exp_re.size() != 0 || exp_tx.size() != 0) && k < 3000) begin
            @(negedge clk_in);
            k++;
        end
        repeat (4) @(negedge clk_in);
        check({tag, "_complete"}, (k < 3000), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     busy,      1'b0);
        check({tag, "_tx_valid"}, tx_valid,  1'b0);
        check({tag, "_tx_data"},  tx_data,   8'h00);
        check({tag, "_mem_addr"}, mem_addr,  11'h000);
        check({tag, "_wdata"},    mem_wdata, 64'h0);
        check({tag, "_we_re"},    {mem_we, mem_re}, 8'h00);
        check({tag, "_pulses"},   {frame_done, frame_err}, 2'b00);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int d0, e0, k;
        rst_in   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset");
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Two-word write to ch0 @ 5, payload 0x00..0x0F.
        d0 = done_cnt; e0 = err_cnt;
        push_write(0, 5, 64'h0706050403020100);
        push_write(0, 6, 64'h0F0E0D0C0B0A0908);
        send_hdr(1'b0, 5'd0, 16'h0005, 2);
        for (int i = 0; i < 15; i++) send_byte(8'(i));
        send_byte(8'h0F);
        check("wr_latency", {mem_we, mem_addr}, {4'b0001, 11'd6});
        check("wr_done_with_we", frame_done, 1'b1);
        wait_idle("wr2");
        check("wr2_done", done_cnt - d0, 1);
        check("wr2_err", err_cnt - e0, 0);

        // Two-word read on ch2 wrapping 0x7FF -> 0x000.
        d0 = done_cnt; e0 = err_cnt;
        push_read(2, 11'h7FF, 2);
        check("rd_exp_first", exp_tx[0], 8'h88);
        check("rd_exp_ninth", exp_tx[8], 8'h11);
        send_hdr(1'b1, 5'd2, 16'h07FF, 2);
        wait_idle("rd_wrap");
        check("rd_wrap_done", done_cnt - d0, 1);
        check("rd_wrap_err", err_cnt - e0, 0);

        // Illegal channel 5 write: payload discarded, next frame decodes.
        d0 = done_cnt; e0 = err_cnt;
        send_hdr(1'b0, 5'd5, 16'h0010, 1);
        send_word(64'h0123456789ABCDEF);
        wait_idle("badch");
        check("badch_err", err_cnt - e0, 1);
        check("badch_done", done_cnt - d0, 0);
        d0 = done_cnt;
        push_write(3, 11'h123, 64'hCAFEF00D12345678);
        send_hdr(1'b0, 5'd3, 16'h0123, 1);
        send_word(64'hCAFEF00D12345678);
        wait_idle("after_badch");
        check("after_badch_done", done_cnt - d0, 1);

        // Stall after 3 payload bytes until the inter-byte timeout fires.
        d0 = done_cnt; e0 = err_cnt;
        send_hdr(1'b0, 5'd1, 16'h0010, 1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        repeat (TIMEOUT_CYCLES - 10) @(negedge clk_in);
        check("tmo_busy_before", busy, 1'b1);
        check("tmo_no_err_yet", err_cnt - e0, 0);
        repeat (20) @(negedge clk_in);
        check("tmo_busy_after", busy, 1'b0);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 0);
        push_write(1, 11'h010, 64'h8877665544332211);
        send_hdr(1'b0, 5'd1, 16'h0010, 1);
        send_word(64'h8877665544332211);
        wait_idle("after_tmo");
        check("after_tmo_done", done_cnt - d0, 1);

        // Stray rx byte while the read is waiting on memory latency.
        d0 = done_cnt; e0 = err_cnt;
        push_read(1, 11'h010, 1);
        send_hdr(1'b1, 5'd1, 16'h0010, 1);
        @(posedge clk_in);
        send_byte(8'hA5);
        wait_idle("rd_inject");
        check("rd_inject_err", err_cnt - e0, 1);
        check("rd_inject_done", done_cnt - d0, 1);

        // Reset in the middle of a write payload.
        send_hdr(1'b0, 5'd0, 16'h0020, 1);
        for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1 check_reset_outputs("rst_wr");
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        d0 = done_cnt;
        push_write(0, 11'h021, 64'h0102030405060708);
        send_hdr(1'b0, 5'd0, 16'h0021, 1);
        send_word(64'h0102030405060708);
        wait_idle("after_rst_wr");
        check("after_rst_wr_done", done_cnt - d0, 1);

        // Reset while bytes are being sent back.
        push_read(2, 11'h7FF, 1);
        send_hdr(1'b1, 5'd2, 16'h07FF, 1);
        k = 0;
        while (!tx_valid && k < 50) begin
            @(negedge clk_in);
            k++;
        end
        check("rst_rd_reached_send", tx_valid, 1'b1);
        @(posedge clk_in);
        #2 rst_in = 1'b0;
        #1 check_reset_outputs("rst_rd");
        exp_tx.delete();
        exp_re.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        d0 = done_cnt;
        push_read(3, 11'h123, 1);
        send_hdr(1'b1, 5'd3, 16'h0123, 1);
        wait_idle("after_rst_rd");
        check("after_rst_rd_done", done_cnt - d0, 1);

        check("illegal_combos", bad_cnt, 0);
        check("unexpected_events", unexp_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
